// File: rtl/hf_bus_pkg.sv
// Shared types for the two-master bus fabric.
// Owner encoding and default hold limit used by the arbiter.
package hf_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam int HOLD_MAX_DEF = 4;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master arbiter onto one shared synchronous memory port.
// Sticky grant with a hold limit under contention; one-cycle read return.
module bus_arbiter
  import hf_bus_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] data0_i,
  input  logic [3:0]  we0_i,
  output logic [31:0] data0_o,
  output logic        stall0_o,
  input  logic        req1_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] data1_i,
  input  logic [3:0]  we1_i,
  output logic [31:0] data1_o,
  output logic        stall1_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_we_n_o,
  output logic [3:0]  mem_cs_n_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [3:0] CntMax = 4'(HOLD_MAX);

  owner_e     owner_q, owner_d;
  owner_e     rd_owner_q;
  owner_e     last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       at_max;

  assign at_max = (cnt_q >= CntMax);

  always_comb begin
    owner_d    = OWN_NONE;
    last_d     = last_q;
    cnt_d      = 4'd0;
    stall0_o   = 1'b1;
    stall1_o   = 1'b1;
    mem_addr_o = 32'h0;
    mem_data_o = 32'h0;
    mem_we_n_o = 4'b1111;
    mem_cs_n_o = 4'b1111;
    data0_o    = 32'h0;
    data1_o    = 32'h0;

    case (owner_q)
      OWN_M0: begin
        if (req0_i && !(req1_i && at_max))
          owner_d = OWN_M0;
        else if (req1_i)
          owner_d = OWN_M1;
      end
      OWN_M1: begin
        if (req1_i && !(req0_i && at_max))
          owner_d = OWN_M1;
        else if (req0_i)
          owner_d = OWN_M0;
      end
      default: begin
        if (req0_i && req1_i)
          owner_d = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
        else if (req0_i)
          owner_d = OWN_M0;
        else if (req1_i)
          owner_d = OWN_M1;
      end
    endcase

    if (owner_d == OWN_NONE) begin
      cnt_d = 4'd0;
    end else if (owner_d == owner_q) begin
      cnt_d = at_max ? CntMax : cnt_q + 4'd1;
    end else begin
      cnt_d  = 4'd1;
      last_d = owner_d;
    end

    if (!rst_i) begin
      stall0_o = req0_i && (owner_d != OWN_M0);
      stall1_o = req1_i && (owner_d != OWN_M1);
      unique case (1'b1)
        owner_d == OWN_M0: begin
          mem_addr_o = addr0_i;
          mem_data_o = data0_i;
          mem_we_n_o = ~we0_i;
          mem_cs_n_o = 4'b0000;
        end
        owner_d == OWN_M1: begin
          mem_addr_o = addr1_i;
          mem_data_o = data1_i;
          mem_we_n_o = ~we1_i;
          mem_cs_n_o = 4'b0000;
        end
        default: ;
      endcase
      // Read data belongs to whoever held the port last cycle.
      if (rd_owner_q == OWN_M0) data0_o = mem_data_i;
      if (rd_owner_q == OWN_M1) data1_o = mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q    <= OWN_NONE;
      rd_owner_q <= OWN_NONE;
      cnt_q      <= 4'd0;
      last_q     <= OWN_M1;
    end else begin
      owner_q    <= owner_d;
      rd_owner_q <= owner_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter.
// Table rows are one clock each; a second instance runs with HOLD_MAX=1.
module tb_bus_arbiter;

  typedef struct {
    logic        rst;
    logic        r0;
    logic        r1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [3:0]  w0;
    logic [3:0]  w1;
    logic [31:0] md;
    logic        s0;
    logic        s1;
    logic [31:0] ma;
    logic [31:0] mdo;
    logic [3:0]  wen;
    logic [3:0]  csn;
    logic [31:0] q0;
    logic [31:0] q1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, req0, req1;
  logic [31:0] addr0, addr1, wd0, wd1, mem_di;
  logic [3:0]  we0, we1;
  logic [31:0] rd0, rd1, mem_a, mem_d;
  logic        st0, st1;
  logic [3:0]  mem_wen, mem_csn;

  logic        rst_b, req0_b, req1_b;
  logic [31:0] rd0_b, rd1_b, mem_a_b, mem_d_b;
  logic        st0_b, st1_b;
  logic [3:0]  mem_wen_b, mem_csn_b;

  int passed = 0;
  int total  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .data0_i(wd0), .we0_i(we0),
    .data0_o(rd0), .stall0_o(st0),
    .req1_i(req1), .addr1_i(addr1), .data1_i(wd1), .we1_i(we1),
    .data1_o(rd1), .stall1_o(st1),
    .mem_addr_o(mem_a), .mem_data_o(mem_d),
    .mem_we_n_o(mem_wen), .mem_cs_n_o(mem_csn),
    .mem_data_i(mem_di)
  );

  bus_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk_i(clk), .rst_i(rst_b),
    .req0_i(req0_b), .addr0_i(32'hA000_0000), .data0_i(32'h0),
    .we0_i(4'h0), .data0_o(rd0_b), .stall0_o(st0_b),
    .req1_i(req1_b), .addr1_i(32'hB000_0000), .data1_i(32'h0),
    .we1_i(4'h0), .data1_o(rd1_b), .stall1_o(st1_b),
    .mem_addr_o(mem_a_b), .mem_data_o(mem_d_b),
    .mem_we_n_o(mem_wen_b), .mem_cs_n_o(mem_csn_b),
    .mem_data_i(32'h5555_5555)
  );

  // Inputs, then expected {s0,s1,ma,mdo,wen,csn,q0,q1}.
  function automatic vec_t mk(
    input logic rs, input logic r0, input logic r1,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [3:0] w0, input logic [3:0] w1,
    input logic [31:0] md,
    input logic s0, input logic s1,
    input logic [31:0] ma, input logic [31:0] mdo,
    input logic [3:0] wen, input logic [3:0] csn,
    input logic [31:0] q0, input logic [31:0] q1);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.w0 = w0; v.w1 = w1; v.md = md;
    v.s0 = s0; v.s1 = s1; v.ma = ma; v.mdo = mdo;
    v.wen = wen; v.csn = csn; v.q0 = q0; v.q1 = q1;
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [137:0] act,
                       input logic [137:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  initial begin
    // Reset, then single master reads at 0x40000000/04/08.
    vq.push_back(mk(1,1,0, 32'h4000_0000,0, 0,0, 0,0, 32'h1111_1111,
                    1,1, 0,0, 4'hF,4'hF, 0,0));
    vq.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 32'h1111_1111,
                    1,1, 0,0, 4'hF,4'hF, 0,0));
    vq.push_back(mk(0,1,0, 32'h4000_0000,0, 0,0, 0,0, 32'h1111_1111,
                    0,0, 32'h4000_0000,0, 4'hF,4'h0, 0,0));
    vq.push_back(mk(0,1,0, 32'h4000_0004,0, 0,0, 0,0, 32'hA0A0_A0A0,
                    0,0, 32'h4000_0004,0, 4'hF,4'h0, 32'hA0A0_A0A0,0));
    vq.push_back(mk(0,1,0, 32'h4000_0008,0, 0,0, 0,0, 32'hA1A1_A1A1,
                    0,0, 32'h4000_0008,0, 4'hF,4'h0, 32'hA1A1_A1A1,0));
    vq.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 32'hA2A2_A2A2,
                    0,0, 0,0, 4'hF,4'hF, 32'hA2A2_A2A2,0));
    // Reset with both requesting: stalls forced, read data squashed.
    vq.push_back(mk(1,1,1, 32'h100,32'h200, 32'h10,32'h20, 0,0, 32'hBAD0_BAD0,
                    1,1, 0,0, 4'hF,4'hF, 0,0));
    // Tie after reset, then contention 0,0,0,0,1,1,1,1,0.
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,1,1, 32'h100,32'h200, 32'h10,32'h20, 0,0,
                      32'hC000_0000 + i,
                      0,1, 32'h100,32'h10, 4'hF,4'h0,
                      (i == 0) ? 32'h0 : 32'hC000_0000 + i, 0));
    vq.push_back(mk(0,1,1, 32'h100,32'h200, 32'h10,32'h20, 0,0, 32'hC000_0004,
                    1,0, 32'h200,32'h20, 4'hF,4'h0, 32'hC000_0004,0));
    for (int i = 5; i < 8; i++)
      vq.push_back(mk(0,1,1, 32'h100,32'h200, 32'h10,32'h20, 0,0,
                      32'hC000_0000 + i,
                      1,0, 32'h200,32'h20, 4'hF,4'h0, 0,32'hC000_0000 + i));
    vq.push_back(mk(0,1,1, 32'h100,32'h200, 32'h10,32'h20, 0,0, 32'hC000_0008,
                    0,1, 32'h100,32'h10, 4'hF,4'h0, 0,32'hC000_0008));
    // Handover M0 -> M1 -> M0 with no idle cycle.
    vq.push_back(mk(0,0,1, 32'h100,32'h200, 32'h10,32'h20, 0,0, 32'hD000_0000,
                    0,0, 32'h200,32'h20, 4'hF,4'h0, 32'hD000_0000,0));
    vq.push_back(mk(0,1,0, 32'h100,32'h200, 32'h10,32'h20, 0,0, 32'hD000_0001,
                    0,0, 32'h100,32'h10, 4'hF,4'h0, 0,32'hD000_0001));
    // M1 write held off while M0 owns; lands exactly once.
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0,1,1, 32'h100,32'h300, 32'h10,32'hDEAD_BEEF, 0,4'hF,
                      32'hE000_0000 + i,
                      0,1, 32'h100,32'h10, 4'hF,4'h0, 32'hE000_0000 + i,0));
    vq.push_back(mk(0,1,1, 32'h100,32'h300, 32'h10,32'hDEAD_BEEF, 0,4'hF,
                    32'hE000_0003,
                    1,0, 32'h300,32'hDEAD_BEEF, 4'h0,4'h0, 32'hE000_0003,0));
    vq.push_back(mk(0,1,0, 32'h100,32'h300, 32'h10,32'hDEAD_BEEF, 0,4'hF,
                    32'hE000_0004,
                    0,0, 32'h100,32'h10, 4'hF,4'h0, 0,32'hE000_0004));
    // Reset right after a granted read.
    vq.push_back(mk(0,1,0, 32'h500,0, 32'h50,0, 0,0, 32'hF000_0000,
                    0,0, 32'h500,32'h50, 4'hF,4'h0, 32'hF000_0000,0));
    vq.push_back(mk(1,1,1, 32'h500,32'h600, 32'h50,32'h60, 0,0, 32'hFACE_FACE,
                    1,1, 0,0, 4'hF,4'hF, 0,0));
    vq.push_back(mk(0,1,1, 32'h500,32'h600, 32'h50,32'h60, 0,0, 32'h7777_7777,
                    0,1, 32'h500,32'h50, 4'hF,4'h0, 0,0));
    vq.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 32'h8888_8888,
                    0,0, 0,0, 4'hF,4'hF, 32'h8888_8888,0));

    rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0;

    foreach (vq[i]) begin
      rst = vq[i].rst; req0 = vq[i].r0; req1 = vq[i].r1;
      addr0 = vq[i].a0; addr1 = vq[i].a1;
      wd0 = vq[i].d0; wd1 = vq[i].d1;
      we0 = vq[i].w0; we1 = vq[i].w1;
      mem_di = vq[i].md;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {st0, st1, mem_a, mem_d, mem_wen, mem_csn, rd0, rd1},
            {vq[i].s0, vq[i].s1, vq[i].ma, vq[i].mdo,
             vq[i].wen, vq[i].csn, vq[i].q0, vq[i].q1});
      @(posedge clk);
      #1;
    end

    // HOLD_MAX=1: continuous contention alternates 0,1,0,1...
    @(posedge clk); #1;
    rst_b = 1'b0; req0_b = 1'b1; req1_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic g1;
      g1 = i[0];
      @(negedge clk);
      check($sformatf("hold1_cyc%0d", i),
            {136'(mem_a_b), st0_b, st1_b},
            {136'(g1 ? 32'hB000_0000 : 32'hA000_0000), g1, !g1});
      @(posedge clk); #1;
    end
    req0_b = 1'b0; req1_b = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-002 The block SHALL have parameter HOLD_MAX, default 4, meaning the maximum number of consecutive granted cycles for one master while the other waits; legal range 1..15.
REQ-003 clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 reqN_i  in  1  master N (N=0,1) requests a bus cycle this clock.
REQ-006 addrN_i  in  32  master N byte address.
REQ-007 dataN_i  in  32  master N write data.
REQ-008 weN_i  in  4  master N byte write enables, active-high; 4'b0000 means read.
REQ-009 dataN_o  out  32  master N read data.
REQ-010 stallN_o  out  1  master N held off this cycle; drives that core's stall_i.
REQ-011 mem_addr_o  out  32  shared memory address.
REQ-012 mem_data_o  out  32  shared memory write data.
REQ-013 mem_we_n_o  out  4  byte write enables, active-low.
REQ-014 mem_cs_n_o  out  4  byte chip selects, active-low.
REQ-015 mem_data_i  in  32  memory read data; valid one cycle after cs_n is asserted.

Function
REQ-016 State SHALL be: owner in {NONE, M0, M1}; last (last master served); cnt (0..HOLD_MAX, saturating); rd_owner in {NONE, M0, M1}.
REQ-017 Grant g SHALL be combinational within the cycle.
- If owner=Mx, req_x=1, and not (req_other=1 and cnt=HOLD_MAX): g=Mx.
- Otherwise, if the other master requests: g=other.
- If owner=NONE and exactly one master requests: g=that master.
- If owner=NONE and both request: g=the master not equal to last.
- Otherwise: g=NONE.
REQ-018 On each clock, the registers SHALL update as follows: owner<=g; rd_owner<=g. When g changed master: cnt<=1 and last<=g. When g=owner: cnt<=min(cnt+1,HOLD_MAX). When g=NONE: cnt<=0.
REQ-019 stallN_o SHALL equal reqN_i AND (g != MN); a master with no request is never stalled.
REQ-020 When g=MN, mem_addr_o, mem_data_o, mem_we_n_o and mem_cs_n_o SHALL be driven as follows:
- mem_addr_o=addrN_i and mem_data_o=dataN_i.
- mem_we_n_o=~weN_i and mem_cs_n_o=4'b0000.
REQ-021 When g=NONE, mem_cs_n_o and mem_we_n_o SHALL be 4'b1111, and mem_addr_o and mem_data_o SHALL be 0.
REQ-022 A stalled master's write SHALL never reach memory.
REQ-023 Read latency SHALL be one cycle: dataN_o=mem_data_i when rd_owner=MN, else 32'h0.
REQ-024 Under continuous contention, each master SHALL wait at most HOLD_MAX cycles; with HOLD_MAX=1, grants alternate every cycle.
REQ-025 When the owner drops its request while the other requests, the grant SHALL transfer in that same cycle, with no idle cycle.
REQ-026 Back-to-back grants to one master SHALL sustain one access per cycle.

Reset
REQ-027 While rst_i=1, the outputs SHALL be: stall0_o=stall1_o=1, mem_cs_n_o=mem_we_n_o=4'b1111, mem_addr_o=mem_data_o=0, data0_o=data1_o=0.
REQ-028 On a clock with rst_i=1, the registers SHALL reset to: owner<=NONE, rd_owner<=NONE, cnt<=0, last<=M1, so that M0 wins the first tie.
REQ-029 Reset mid-access SHALL discard any in-flight read; the cycle after reset releases, data outputs are 0.

Structure
REQ-030 The owner encoding type (NONE/M0/M1, 2 bits) and the HOLD_MAX default SHALL reside in the shared package hf_bus_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; the grant logic SHALL be one combinational process and the state one clocked process.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Single master: req0=1 for 3 cycles, addr 0x40000000/04/08, reads. Required: stall0_o=0 throughout; data0_o returns mem words 1 cycle later; data1_o=0.
- Tie after reset: req0=req1=1 at the first post-reset cycle. Required: M0 granted, stall1_o=1.
- Contention with HOLD_MAX=4: both requesting continuously. Required: grant pattern 0,0,0,0,1,1,1,1,0…
- Handover: owner M1 drops req1 while req0=1. Required: M0 granted in the same cycle; no cycle with cs_n=4'b1111.
- Stalled write: M1 write, we1=4'b1111, data 0xDEADBEEF, while M0 owns. Required: memory sees no we_n low for M1 until it is granted; the write then lands once.
- Reset mid-read: rst_i=1 the cycle after a granted read. Required: data0_o=0 next cycle; stalls=1 during reset; M0 wins the next tie.
